agu_mem_read_responder: RTL and testbench
=========================================

Name: agu_mem_read_responder

Overview:
Consumer end of the address-generation stream. Accepts addr/addr_valid/addr_ready handshakes from an address generator and issues one fixed-latency SRAM read per accepted address. Returned words are buffered in a small credit-protected FIFO and presented as an ordered data stream to the compute datapath, so no read data is lost under downstream backpressure. The block sits between the address generator, the scratchpad SRAM and the PE array input.

Parameters:
ADDR_WIDTH, 16, address width; matches the address generator output.
DATA_WIDTH, 32, SRAM word width.
RD_LATENCY, 2, cycles from mem_rd_en to valid mem_rdata; range 1..4.
FIFO_DEPTH, 4, response FIFO entries; power of two, at least RD_LATENCY+1.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  level; begin a transfer, latched in IDLE.
length  in  16  number of words to read; sampled on start in IDLE.
done  out  1  high while in DONE.
addr  in  ADDR_WIDTH  read address from the generator.
addr_valid  in  1  address valid.
addr_ready  out  1  block can accept an address this cycle.
mem_rd_en  out  1  SRAM read strobe.
mem_addr  out  ADDR_WIDTH  SRAM read address.
mem_rdata  in  DATA_WIDTH  SRAM read data, valid RD_LATENCY cycles after mem_rd_en.
out_data  out  DATA_WIDTH  head-of-FIFO word.
out_valid  out  1  FIFO non-empty.
out_ready  in  1  downstream accepts out_data.

Behaviour:
- Reset (async, rst_n low): state=IDLE. done, addr_ready, mem_rd_en, out_valid are 0. mem_addr and out_data are 0. Counters, the latency pipe and the FIFO are cleared. Reads in flight are discarded: returns for pre-reset reads are never pushed.
- States:
  - IDLE: if start, latch length into len_q and clear issued_cnt and delivered_cnt. Go to DONE if length==0, otherwise go to RUN.
  - RUN: leave to DONE in the cycle after delivered_cnt reaches len_q (the final pop).
  - DONE: done=1; go to IDLE when start==0. start held high keeps the block in DONE.
- Credit: occ = inflight + fifo_count. inflight is the number of 1s in the RD_LATENCY-deep valid shift register. Pops in the same cycle are not credited.
- addr_ready = (state==RUN) && (issued_cnt < len_q) && (occ < FIFO_DEPTH). It is 0 in IDLE and DONE.
- Accept: accept = addr_valid && addr_ready.
  - mem_rd_en = accept, combinational.
  - mem_addr = addr when accept, otherwise the last accepted address (registered hold).
  - issued_cnt increments on accept.
- Latency pipe: the valid bit shifts each cycle. When its output is 1, mem_rdata is pushed into the FIFO at that clock edge.
- Push and pop in the same cycle are both honoured. The credit rule guarantees a push never finds the FIFO full.
- Latency: address handshake at edge t gives out_valid at t+RD_LATENCY+1, assuming the FIFO was empty.
- Ordering: strict FIFO; outputs follow address acceptance order.
- Output handshake: pop when out_valid && out_ready. out_data and out_valid stay stable while out_valid && !out_ready. delivered_cnt increments on each pop.
- Throughput: one address per cycle when out_ready is held at 1 and FIFO_DEPTH >= RD_LATENCY+2. With defaults: occ peaks at 3 < 4.
- Counter widths are 16 bits; length up to 65535 is supported with no wrap.
- Addresses presented beyond len_q are not accepted (addr_ready=0).
- A change of start while in RUN is ignored.

Test Plan:
1. Length 8, addr 0x100..0x107 back-to-back, out_ready=1, SRAM model returns {16'hA5A5, addr} -> addr_ready stays 1 for 8 cycles. The first out_valid is 3 cycles after the first accept. Words arrive in order 0xA5A50100..0xA5A50107. done rises the cycle after the 8th pop.
2. Length 8, out_ready=0 -> exactly 4 addresses accepted, then addr_ready=0 and out_data holds 0xA5A50100 steady. Raise out_ready -> remaining 4 accepted; all 8 words delivered in order with none dropped or duplicated.
3. length=0, start pulse -> next cycle done=1; mem_rd_en never asserts. start low -> IDLE.
4. Length 8: assert rst_n=0 after 3 accepts, release, start length 2 at 0x200 -> only 0xA5A50200 and 0xA5A50201 emerge; no stale pre-reset data.
5. start held high through completion -> done stays 1. Lower start -> IDLE next cycle. A new start with length 1 completes normally.
6. Length 4, addr_valid toggling 1,0,1,0 and out_ready toggling 0,1 -> 4 words delivered in order. mem_rd_en pulses only on accept cycles; occ never exceeds 4.

Source files
------------

// File: rtl/agu_mem_read_responder.sv
// Accepts generator addresses, issues fixed-latency SRAM reads and returns the words in order
// through a credit-protected FIFO so downstream backpressure never drops read data.
module agu_mem_read_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [15:0]           length,
    output logic                  done,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  addr_valid,
    output logic                  addr_ready,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                  state_q, state_d;
    logic [15:0]             len_q, len_d;
    logic [15:0]             issued_q, issued_d;
    logic [15:0]             delivered_q, delivered_d;
    logic [RD_LATENCY-1:0]   vpipe_q, vpipe_d;
    logic [ADDR_WIDTH-1:0]   hold_q;
    logic [DATA_WIDTH-1:0]   fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wptr_q, rptr_q;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W:0]          inflight;
    logic [CNT_W:0]          occ;
    logic                    accept, push, pop;

    // Credit counts every read already issued, so a push can never meet a full FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + {{CNT_W{1'b0}}, vpipe_q[i]};
        end
        occ = inflight + {1'b0, count_q};
    end

    assign addr_ready = (state_q == RUN) && (issued_q < len_q) && (occ < DEPTH_C);
    assign accept     = addr_valid && addr_ready;
    assign mem_rd_en  = accept;
    assign mem_addr   = accept ? addr : hold_q;
    assign push       = vpipe_q[RD_LATENCY-1];
    assign out_valid  = (count_q != '0);
    assign pop        = out_valid && out_ready;
    assign out_data   = fifo_q[rptr_q];
    assign done       = (state_q == DONE);

    always_comb begin
        vpipe_d[0] = accept;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d       = length;
                    issued_d    = '0;
                    delivered_d = '0;
                    state_d     = (length == 16'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    issued_d = issued_q + 16'd1;
                end
                if (pop) begin
                    delivered_d = delivered_q + 16'd1;
                    if (delivered_q + 16'd1 == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            vpipe_q     <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            vpipe_q     <= vpipe_d;
            if (accept) begin
                hold_q <= addr;
            end
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= mem_rdata;
                wptr_q         <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_agu_mem_read_responder.sv
// Randomized scoreboard bench: accepted addresses queue their expected SRAM word and a
// negedge monitor pops and compares whenever a word leaves the block.
module tb_agu_mem_read_responder;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int L  = 2;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   length = '0;
    logic          done;
    logic [AW-1:0] addr = '0;
    logic          addr_valid = 1'b0;
    logic          addr_ready;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;

    int nChecks = 0;
    int nFails = 0;
    int cycle = 0;

    logic [DW-1:0] expQ[$];
    int            acceptCycles[$];
    int            lenM = 0;
    int            issuedM = 0;
    int            poppedM = 0;
    bit            runFlag = 0;
    bit            doneDue = 0;
    bit            holdPrev = 0;
    bit            checkLat = 0;
    logic [DW-1:0] holdData = '0;
    logic [AW-1:0] memPipe [L];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // SRAM model: each word is {A5A5, address}, returned L cycles after the read strobe.
    always @(posedge clk) begin
        for (int i = L - 1; i > 0; i--) memPipe[i] <= memPipe[i-1];
        memPipe[0] <= mem_addr;
    end
    assign mem_rdata = {16'hA5A5, memPipe[L-1]};

    agu_mem_read_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .length(length), .done(done),
        .addr(addr), .addr_valid(addr_valid), .addr_ready(addr_ready),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    // Monitor: credit model for addr_ready, scoreboard for the output stream, done and hold checks.
    always @(negedge clk) begin
        if (rst_n) begin
            automatic bit expReady = runFlag && (issuedM < lenM) && ((issuedM - poppedM) < D);
            automatic bit acc = addr_valid && addr_ready;
            checkOutput("addr_ready", {31'd0, addr_ready}, {31'd0, expReady});
            checkOutput("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, acc});
            if (acc) checkOutput("mem_addr", {16'd0, mem_addr}, {16'd0, addr});
            if (doneDue) begin
                checkOutput("done_after_last_pop", {31'd0, done}, 32'd1);
                doneDue = 0;
            end
            if (holdPrev) begin
                checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
                checkOutput("hold_data", out_data, holdData);
            end
            if (acc) begin
                expQ.push_back({16'hA5A5, addr});
                acceptCycles.push_back(cycle);
                issuedM++;
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_word", out_data, 32'hFFFF_FFFF);
                end else begin
                    automatic int accCyc = acceptCycles.pop_front();
                    checkOutput("data_order", out_data, expQ.pop_front());
                    if (checkLat) checkOutput("latency", cycle - accCyc, L + 1);
                end
                poppedM++;
                if (poppedM == lenM) begin
                    runFlag = 0;
                    doneDue = 1;
                end
            end
            holdPrev = out_valid && !out_ready;
            holdData = out_data;
        end
    end

    task automatic applyReset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        addr_valid = 1'b0;
        start = 1'b0;
        expQ.delete();
        acceptCycles.delete();
        runFlag = 0;
        doneDue = 0;
        holdPrev = 0;
        #2;
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_addr_ready", {31'd0, addr_ready}, 32'd0);
        checkOutput("rst_mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic startTransfer(input int len, input bit hold);
        @(posedge clk); #1;
        start = 1'b1;
        length = len[15:0];
        @(posedge clk); #1;
        lenM = len;
        issuedM = 0;
        poppedM = 0;
        runFlag = (len != 0);
        if (!hold) start = 1'b0;
    endtask

    // vMode: 0 always valid, 1 toggling, 2 random. rMode: 0 always ready, 1 toggling, 2 stalled then ready, 3 random.
    task automatic applyStimulus(input int len, input logic [AW-1:0] base, input int vMode, input int rMode,
                                 input bit hold, input int resetAt, input bit lat);
        int idx = 0;
        int cyc = 0;
        bit finished = 0;
        checkLat = lat;
        startTransfer(len, hold);
        while (!finished && cyc < 300) begin
            @(posedge clk); #1;
            addr_valid = (idx < len) && (vMode == 0 || (vMode == 1 && cyc % 2 == 0) ||
                                         (vMode == 2 && $urandom_range(0, 3) != 0));
            addr = base + AW'(idx);
            case (rMode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 2 == 1);
                2: out_ready = (cyc >= 12);
                default: out_ready = ($urandom_range(0, 1) == 1);
            endcase
            if (rMode == 2 && cyc == 11) begin
                checkOutput("stall_accepts", idx, D);
                checkOutput("stall_head", out_data, {16'hA5A5, base});
            end
            @(negedge clk);
            if (addr_valid && addr_ready) idx++;
            if (resetAt != 0 && idx == resetAt) begin
                applyReset();
                return;
            end
            if (done) finished = 1;
            cyc++;
        end
        checkOutput("transfer_finished", {31'd0, finished}, 32'd1);
        checkOutput("words_delivered", poppedM, len);
        checkOutput("scoreboard_empty", expQ.size(), 0);
        addr_valid = 1'b0;
        checkLat = 0;
        if (hold) begin
            repeat (3) begin
                @(negedge clk);
                checkOutput("done_held", {31'd0, done}, 32'd1);
            end
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
        end
        @(negedge clk);
        checkOutput("back_to_idle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        applyReset();
        $display("[TB] back-to-back length 8");
        applyStimulus(8, 16'h0100, 0, 0, 0, 0, 1);
        $display("[TB] backpressure length 8");
        applyStimulus(8, 16'h0100, 0, 2, 0, 0, 0);

        $display("[TB] zero length");
        @(posedge clk); #1;
        start = 1'b1; length = 16'd0; addr_valid = 1'b1; addr = 16'h0300;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        checkOutput("len0_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        checkOutput("len0_idle", {31'd0, done}, 32'd0);
        addr_valid = 1'b0;

        $display("[TB] reset mid-transfer");
        applyStimulus(8, 16'h0150, 0, 0, 0, 3, 0);
        applyStimulus(2, 16'h0200, 0, 0, 0, 0, 0);

        $display("[TB] start held through completion");
        applyStimulus(3, 16'h0280, 0, 0, 1, 0, 0);
        applyStimulus(1, 16'h0400, 0, 0, 0, 0, 0);

        $display("[TB] toggling valid and ready");
        applyStimulus(4, 16'h0500, 1, 1, 0, 0, 0);

        $display("[TB] random transfers");
        for (int t = 0; t < 6; t++) begin
            applyStimulus($urandom_range(1, 20), 16'($urandom), 2, 3, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
